// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, one full-adder slice per clock, LSB first.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, res_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, carry_d, bit_d, busy_q, done_q, cout_q;
  always_comb begin
    bit_d   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_d = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    res_d   = {bit_d, res_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          a_sh_q  <= a;
          b_sh_q  <= b;
          carry_q <= 1'b0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
      end else begin
        a_sh_q  <= a_sh_q >> 1;
        b_sh_q  <= b_sh_q >> 1;
        carry_q <= carry_d;
        res_q   <= res_d;
        // the counter stops at WIDTH-1 so it never wraps within an operation
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_q   <= res_d;
          cout_q  <= carry_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder against a cycle-level reference model.
module tb_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  int           n_cmp = 0, n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: an accepted add finishes exactly W edges later with the full a+b value.
  int         cyc = 0;
  int         due = -1;
  logic [W:0] pend = '0, exp_res = '0;
  logic       exp_done = 1'b0, exp_busy = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      due      = -1;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_res  = '0;
    end else begin
      cyc++;
      exp_done = 1'b0;
      if (due == cyc) begin
        exp_done = 1'b1;
        exp_busy = 1'b0;
        exp_res  = pend;
        due      = -1;
      end else if (due < 0 && start) begin
        pend     = {1'b0, a} + {1'b0, b};
        due      = cyc + W;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("model_done", {31'd0, done}, {31'd0, exp_done});
    chk("model_sum", {24'd0, sum}, {24'd0, exp_res[W-1:0]});
    chk("model_cout", {31'd0, cout}, {31'd0, exp_res[W]});
  end

  // Returns edges from the acceptance edge to the done edge; busy must stay high meanwhile.
  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!done) chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    end while (!done && n < 40);
  endtask

  task automatic op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x; b = ~y;
    wait_done(nm, n);
    chk({nm, "_lat"}, n, W);
    chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  initial begin
    int n, nd;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(posedge clk);

    op("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    op("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    op("add_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
    op("add_a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);

    // start pulse and operand changes mid-run must not disturb the running add
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        chk("ignore_lat", i, W);
        chk("ignore_sum", {24'd0, sum}, 32'h46);
        chk("ignore_cout", {31'd0, cout}, 32'd0);
      end
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 3) begin start = 1'b0; a = 8'h77; b = 8'h99; end
    end
    chk("ignore_ndone", nd, 1);

    // start held high across done: next add begins on the edge after done
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("b2b1", n);
    chk("b2b1_lat", n, W);
    chk("b2b1_sum", {24'd0, sum}, 32'h03);
    chk("b2b1_cout", {31'd0, cout}, 32'd0);
    a = 8'h80; b = 8'h80;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b2", n);
    chk("b2b2_lat", n, W);
    chk("b2b2_sum", {24'd0, sum}, 32'h00);
    chk("b2b2_cout", {31'd0, cout}, 32'd1);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum", {24'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("arst_no_done", nd, 0);
    op("after_rst", 8'h05, 8'h03, 8'h08, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to add a and b; sampled on the rising clk edge.
REQ-005 Port: a  input  WIDTH  first operand, unsigned; captured on the accepting edge only.
REQ-006 Port: b  input  WIDTH  second operand, unsigned; captured on the accepting edge only.
REQ-007 Port: busy  output  1  high while an addition is in progress.
REQ-008 Port: done  output  1  registered one-cycle pulse marking a new result.
REQ-009 Port: sum  output  WIDTH  registered result, low WIDTH bits of a+b.
REQ-010 Port: cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have two states: IDLE and RUN.
REQ-012 IDLE with start=1 at edge k SHALL accept the operation:
- load operand shift registers with a and b;
- clear the carry flip-flop and the bit counter;
- enter RUN and set busy=1.
REQ-013 IDLE with start=0 SHALL remain in IDLE with busy=0.
REQ-014 Each RUN edge SHALL process one bit, LSB first, with a single 1-bit full-adder slice:
- result bit = a_sh[0] ^ b_sh[0] ^ carry;
- next carry = majority(a_sh[0], b_sh[0], carry);
- result bit shifts into the MSB of an internal result register;
- a_sh and b_sh shift right by one;
- the counter increments.
REQ-015 The edge processing bit WIDTH-1 (edge k+WIDTH) SHALL:
- load sum from the internal result register, including the final bit;
- load cout from the final carry;
- set done=1 and busy=0;
- return the FSM to IDLE.
REQ-016 Latency SHALL be exactly WIDTH cycles from the accepting edge to the edge that asserts done.
REQ-017 done SHALL be high for exactly one cycle per accepted operation and SHALL never assert otherwise.
REQ-018 sum and cout SHALL hold their previous values throughout RUN and change only on a completion edge.
REQ-019 start SHALL be ignored while in RUN; the operation in progress and its operands SHALL be unaffected.
REQ-020 start=1 during the done cycle (FSM already in IDLE) SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-021 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with {cout,sum} equal to a+b as a WIDTH+1-bit value.
REQ-023 The counter SHALL be wide enough for WIDTH-1 and SHALL NOT wrap during an operation.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, clear all of the following: FSM to IDLE, busy, done, sum, cout, carry, counter, and the internal shift registers.
REQ-025 rst asserted during RUN SHALL abort the operation with no done pulse; the first edge after rst deasserts SHALL be able to accept a new start.

Verification
REQ-026 WIDTH=8, a=0x0F, b=0x01, start pulse at edge k -> busy high edges k..k+7, done at edge k+8, sum=0x10, cout=0.
REQ-027 WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-028 Accept a=0x12, b=0x34; at edge k+3 pulse start with a=0xFF, b=0xFF and change a/b -> single done, sum=0x46, cout=0.
REQ-029 Hold start=1 across done with a=0x01, b=0x02 then a=0x80, b=0x80:
- first done: sum=0x03, cout=0;
- second done exactly 8 cycles later: sum=0x00, cout=1.
REQ-030 Assert rst between clock edges at edge k+4 of an operation -> busy, done, sum, cout go 0 immediately, no done follows; a new add of 0x05+0x03 afterwards gives sum=0x08.
